// File: rtl/fetch_stage.sv
// RV32 instruction fetch stage: fetch PC, in-order imem requests, response queue to decode.
// Optional FETCH_MISALIGN_TRAP_EN turns misaligned redirect targets into a marker entry.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        dec_misalign
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]      fpc;
    logic [31:0]      slot_pc    [DEPTH];
    logic [31:0]      slot_instr [DEPTH];
    logic [DEPTH-1:0] slot_filled;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    fill_ptr;
    logic [CW-1:0]    used;
    logic [CW-1:0]    pending;
    logic [CW-1:0]    drop;
    logic             halt;

    logic             pop;
    logic             req_fire;
    logic             rsp_any;
    logic             rsp_drop;
    logic             rsp_take;
    logic             misalign;
    logic [CW:0]      credit;
    logic [CW:0]      drop_sum;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign     = |redirect_pc[1:0];
    assign dec_misalign = dec_valid && halt;
`else
    assign misalign     = 1'b0;
    assign dec_misalign = 1'b0;
`endif

    assign dec_valid = (used != '0) && slot_filled[rd_ptr];
    assign dec_instr = slot_instr[rd_ptr];
    assign dec_pc    = slot_pc[rd_ptr];

    assign pop = dec_valid && dec_ready && !redirect;

    // Credits cover live slots plus responses still owed to a flushed stream.
    assign credit = {1'b0, used} + {1'b0, drop} - (CW+1)'(pop);

    assign imem_req_valid = !redirect && !halt
                         && (credit < (CW+1)'(DEPTH));
    assign imem_req_addr  = fpc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_any  = imem_rsp_valid && ((drop != '0) || (pending != '0));
    assign rsp_drop = imem_rsp_valid && (drop != '0);
    assign rsp_take = imem_rsp_valid && (drop == '0) && (pending != '0);

    // Everything still owed by memory after a flush must be discarded.
    assign drop_sum = {1'b0, drop} + {1'b0, pending} - (CW+1)'(rsp_any);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc         <= RESET_PC;
            slot_filled <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill_ptr    <= '0;
            used        <= '0;
            pending     <= '0;
            drop        <= '0;
            halt        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc[i]    <= '0;
                slot_instr[i] <= '0;
            end
        end else if (redirect) begin
            fpc         <= redirect_pc & ~32'h0000_0003;
            slot_filled <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill_ptr    <= '0;
            used        <= '0;
            pending     <= '0;
            drop        <= drop_sum[CW-1:0];
            halt        <= misalign;
            if (misalign) begin
                slot_pc[0]     <= redirect_pc;
                slot_instr[0]  <= NOP;
                slot_filled[0] <= 1'b1;
                wr_ptr         <= AW'(1);
                fill_ptr       <= AW'(1);
                used           <= CW'(1);
            end
        end else begin
            if (req_fire) begin
                slot_pc[wr_ptr] <= fpc;
                wr_ptr          <= wr_ptr + AW'(1);
                fpc             <= fpc + 32'd4;
            end
            if (rsp_drop) begin
                drop <= drop - CW'(1);
            end
            if (rsp_take) begin
                slot_instr[fill_ptr]  <= imem_rsp_data;
                slot_filled[fill_ptr] <= 1'b1;
                fill_ptr              <= fill_ptr + AW'(1);
            end
            if (pop) begin
                slot_filled[rd_ptr] <= 1'b0;
                rd_ptr              <= rd_ptr + AW'(1);
            end
            used    <= used + CW'(req_fire) - CW'(pop);
            pending <= pending + CW'(req_fire) - CW'(rsp_take);
        end
    end

endmodule
